log_mul_scheduler: RTL and testbench

LOG_MUL_SCHEDULER -- requirements
Module: log_mul_scheduler

---
 rtl/log_pkg.sv | 56 +++++
 rtl/rr_arbiter.sv | 31 +++
 rtl/log_mul_scheduler.sv | 141 ++++++++++++++
 tb/tb_log_mul_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/log_pkg.sv
// Shared definitions for the logarithmic-number multiply scheduler.
// LogNumber layout is {sign, logExp[M-1:0], logFrac[F-1:0]}. The reserved
// encodings are: zero = 0 followed by all ones, inf = all ones.
// The helpers take the field widths as arguments and return a
// LN_MAX_W-wide value that callers truncate to 1+M+F bits.
package log_pkg;

  localparam int unsigned LN_M_DEF = 3;
  localparam int unsigned LN_F_DEF = 4;
  localparam int unsigned LN_MAX_W = 32;
  localparam int unsigned ID_MAX_W = 8;

  // Special-value classification carried alongside the exponent sum.
  typedef enum logic [1:0] {
    SPC_NONE = 2'd0,
    SPC_ZERO = 2'd1,
    SPC_INF  = 2'd2
  } spc_e;

  // Contents of pipeline stage S1: decoded specials plus the unbiased log sum.
  typedef struct packed {
    logic                       valid;
    logic [ID_MAX_W-1:0]        id;
    logic                       sign;
    spc_e                       spc;
    logic signed [LN_MAX_W-1:0] xp;
  } stage_t;

  function automatic logic [LN_MAX_W-1:0] ln_ones(input int unsigned n);
    return (LN_MAX_W'(1) << n) - LN_MAX_W'(1);
  endfunction

  function automatic logic [LN_MAX_W-1:0] ln_zero(input int unsigned m, input int unsigned f);
    return ln_ones(m + f);
  endfunction

  function automatic logic [LN_MAX_W-1:0] ln_inf(input int unsigned m, input int unsigned f);
    return ln_ones(1 + m + f);
  endfunction

  // Largest finite magnitude: exponent all ones, fraction all ones except LSB.
  function automatic logic [LN_MAX_W-1:0] ln_max(input logic sign, input int unsigned m,
                                                 input int unsigned f);
    return (LN_MAX_W'(sign) << (m + f)) | (ln_ones(m + f) - LN_MAX_W'(1));
  endfunction

  function automatic logic [LN_MAX_W-1:0] ln_bias(input int unsigned m, input int unsigned f);
    return LN_MAX_W'(1) << (m - 1 + f);
  endfunction

  // Largest {logExp,logFrac} value that is not the reserved all-ones pattern.
  function automatic logic [LN_MAX_W-1:0] ln_xmax(input int unsigned m, input int unsigned f);
    return ln_ones(m + f) - LN_MAX_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector.
//   req         : request vector, one bit per requester
//   ptr         : requester with highest priority this cycle
//   grant_valid : at least one request is set
//   grant_idx   : first requester with req set, searching from ptr upward
//                 and wrapping N-1 -> 0
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  always_comb begin
    logic [IW-1:0] idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IW'((32'(ptr) + i) % N);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/log_mul_scheduler.sv
// Multiplies LogNumber operand pairs from N requesters through a two-stage
// pipeline, granting one requester per cycle in round-robin order.
//   clock, resetn      : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready  : per-requester handshake (at most one ready bit high)
//   in_a, in_b         : per-requester operands {sign, logExp, logFrac}
//   out_valid/out_ready: result handshake
//   out_data, out_id   : product and the index of the requester that issued it
//   busy               : either pipeline stage holds a valid operation
module log_mul_scheduler
  import log_pkg::*;
#(
  parameter  int unsigned M  = LN_M_DEF,
  parameter  int unsigned F  = LN_F_DEF,
  parameter  int unsigned N  = 4,
  localparam int unsigned W  = 1 + M + F,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [N-1:0]        in_valid,
  output logic [N-1:0]        in_ready,
  input  logic [N-1:0][W-1:0] in_a,
  input  logic [N-1:0][W-1:0] in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        out_data,
  output logic [IW-1:0]       out_id,
  output logic                busy
);

  localparam logic [W-1:0]               ZERO_ENC = W'(ln_zero(M, F));
  localparam logic [W-1:0]               INF_ENC  = W'(ln_inf(M, F));
  localparam logic [W-1:0]               MAX_POS  = W'(ln_max(1'b0, M, F));
  localparam logic [W-1:0]               MAX_NEG  = W'(ln_max(1'b1, M, F));
  localparam logic [LN_MAX_W-1:0]        BIAS     = ln_bias(M, F);
  localparam logic signed [LN_MAX_W-1:0] XMAX     = $signed(ln_xmax(M, F));

  stage_t        s1_q, s1_d, s_new;
  logic          s2_valid_q, s2_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [IW-1:0] out_id_q, out_id_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic          adv, accept;
  logic [W-1:0]  a_sel, b_sel, res;
  logic signed [LN_MAX_W-1:0] xp_s1;

  rr_arbiter #(.N(N)) u_arb (
    .req         (in_valid),
    .ptr         (ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // resetn is folded in so no requester sees ready while reset is asserted.
  always_comb begin
    adv      = !s2_valid_q || out_ready;
    accept   = resetn && adv && grant_valid;
    in_ready = '0;
    if (accept) in_ready[grant_idx] = 1'b1;
  end

  // S1 input: classify specials and form the unbiased exponent sum.
  always_comb begin
    a_sel      = in_a[grant_idx];
    b_sel      = in_b[grant_idx];
    s_new      = '0;
    s_new.valid = accept;
    s_new.id   = ID_MAX_W'(grant_idx);
    s_new.sign = a_sel[W-1] ^ b_sel[W-1];
    if (a_sel == INF_ENC || b_sel == INF_ENC) begin
      s_new.spc = SPC_INF;
    end else if (a_sel == ZERO_ENC || b_sel == ZERO_ENC) begin
      s_new.spc = SPC_ZERO;
    end else begin
      s_new.spc = SPC_NONE;
    end
    s_new.xp = $signed(LN_MAX_W'(a_sel[M+F-1:0]) + LN_MAX_W'(b_sel[M+F-1:0]) - BIAS);
  end

  // S2 input: saturate/flush the sum into the final encoding.
  always_comb begin
    xp_s1 = s1_q.xp;
    case (s1_q.spc)
      SPC_INF:  res = INF_ENC;
      SPC_ZERO: res = ZERO_ENC;
      default: begin
        if (xp_s1 > XMAX) begin
          res = s1_q.sign ? MAX_NEG : MAX_POS;
        end else if (xp_s1 < 0) begin
          res = ZERO_ENC;
        end else begin
          res = {s1_q.sign, xp_s1[M+F-1:0]};
        end
      end
    endcase
  end

  always_comb begin
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    ptr_d      = ptr_q;
    if (adv) begin
      s1_d       = s_new;
      s2_valid_d = s1_q.valid;
      if (s1_q.valid) begin
        out_data_d = res;
        out_id_d   = IW'(s1_q.id);
      end
    end
    if (accept) begin
      ptr_d = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      out_data_q <= '0;
      out_id_q   <= '0;
      ptr_q      <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
      ptr_q      <= ptr_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign busy      = s1_q.valid || s2_valid_q;

endmodule

// File: tb/tb_log_mul_scheduler.sv
// Scoreboard bench for log_mul_scheduler (M=3, F=4, N=4).
module tb_log_mul_scheduler;

  localparam int unsigned M  = 3;
  localparam int unsigned F  = 4;
  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned IW = 2;
  localparam int          NV = 16;

  logic                clock = 1'b0;
  logic                resetn = 1'b0;
  logic [N-1:0]        in_valid;
  logic [N-1:0]        in_ready;
  logic [N-1:0][W-1:0] in_a;
  logic [N-1:0][W-1:0] in_b;
  logic                out_valid;
  logic                out_ready;
  logic [W-1:0]        out_data;
  logic [IW-1:0]       out_id;
  logic                busy;

  log_mul_scheduler #(.M(M), .F(F), .N(N)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  data;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] exp_tbl [N];
  int checks = 0, failures = 0, pushed = 0, popped = 0, flushed = 0;

  // Directed vectors: a, b, hand-computed product.
  logic [W-1:0] va [NV] = '{8'h7E, 8'hD0, 8'h00, 8'h7F, 8'hFF, 8'hFF, 8'hC0, 8'h30,
                            8'h7E, 8'h7E, 8'h20, 8'h20, 8'hFE, 8'h80, 8'h7F, 8'h80};
  logic [W-1:0] vb [NV] = '{8'h7E, 8'h50, 8'h00, 8'h50, 8'h7F, 8'hC0, 8'hC0, 8'h50,
                            8'h40, 8'h41, 8'h20, 8'h1F, 8'h7E, 8'h00, 8'hFF, 8'h7F};
  // 7Ex7E sat; -2*2=-4; underflow; zero; inf>zero; inf; -1*-1; .5*2;
  // Xp=126 exact; Xp=127 sat; Xp=0; Xp=-1 flush; neg sat; neg flush; inf>zero; -x0
  logic [W-1:0] ve [NV] = '{8'h7E, 8'hE0, 8'h7F, 8'h7F, 8'hFF, 8'hFF, 8'h40, 8'h40,
                            8'h7E, 8'h7E, 8'h00, 8'h7F, 8'hFE, 8'h7F, 8'hFF, 8'h7F};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Input side of the scoreboard: record each accepted beat in order.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (resetn) begin
        for (int r = 0; r < N; r++) begin
          if (in_valid[r] && in_ready[r]) begin
            e.id   = IW'(r);
            e.data = exp_tbl[r];
            exp_q.push_back(e);
            pushed++;
          end
        end
      end
    end
  end

  // Output side: compare every delivered result against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (resetn) begin
        check("in_ready_onehot", 32'($countones(in_ready) > 1), 0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: actual data 0x%0h id %0d, required no output",
                     out_data, out_id);
          end else begin
            e = exp_q.pop_front();
            popped++;
            check("out_data", out_data, e.data);
            check("out_id", out_id, e.id);
          end
        end
      end
    end
  end

  task automatic send(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] e);
    bit acc;
    int cnt;
    in_a[r] = a;
    in_b[r] = b;
    exp_tbl[r] = e;
    in_valid[r] = 1'b1;
    acc = 1'b0;
    cnt = 0;
    while (!acc && cnt < 50) begin
      @(negedge clock);
      acc = in_ready[r];
      cnt++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: req %0d not accepted, required accept within 50 cycles", r);
    end
    @(posedge clock);
    #1;
    in_valid[r] = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int cnt;
    cnt = 0;
    while ((busy || exp_q.size() != 0) && cnt < 100) begin
      @(posedge clock);
      #1;
      cnt++;
    end
    check({tag, "_drained"}, 32'(busy || exp_q.size() != 0), 0);
  endtask

  initial begin
    int acc_n;
    int cnt;
    bit acc;
    logic [W-1:0] bp_b [3] = '{8'h50, 8'h60, 8'h30};
    logic [W-1:0] rr_b [N] = '{8'h40, 8'h50, 8'h60, 8'h30};

    in_valid  = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    for (int r = 0; r < N; r++) exp_tbl[r] = '0;

    // Reset state, with requests present to show ready stays low.
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_id", out_id, 0);
    in_valid = '1;
    #1;
    check("rst_in_ready", in_ready, 0);
    in_valid = '0;
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // Basic product and two-edge latency.
    send(0, 8'h40, 8'h50, 8'h50);
    check("lat_s1_out_valid", out_valid, 0);
    check("lat_s1_busy", busy, 1);
    @(posedge clock);
    #1;
    check("lat_s2_out_valid", out_valid, 1);
    check("basic_out_data", out_data, 8'h50);
    check("basic_out_id", out_id, 0);

    // Arithmetic, saturation, flush and special-value vectors.
    for (int i = 0; i < NV; i++) send(i % N, va[i], vb[i], ve[i]);

    // Backpressure: stall the output with requester 1 continuously valid.
    wait_drain("pre_bp");
    out_ready   = 1'b0;
    in_a[1]     = 8'h40;
    in_b[1]     = bp_b[0];
    exp_tbl[1]  = bp_b[0];
    in_valid[1] = 1'b1;
    acc_n = 0;
    repeat (5) begin
      @(negedge clock);
      if (in_ready[1]) acc_n++;
      if (out_valid) begin
        check("bp_hold_data", out_data, 8'h50);
        check("bp_hold_id", out_id, 1);
      end
      @(posedge clock);
      #1;
      if (acc_n < 3) begin
        in_b[1]    = bp_b[acc_n];
        exp_tbl[1] = bp_b[acc_n];
      end
    end
    check("bp_accepted", 32'(acc_n), 2);
    @(negedge clock);
    check("bp_ready_low", in_ready, 0);
    check("bp_valid_held", out_valid, 1);
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    acc = 1'b0;
    cnt = 0;
    while (!acc && cnt < 20) begin
      @(negedge clock);
      acc = in_ready[1];
      cnt++;
    end
    check("bp_third_accept", 32'(acc), 1);
    @(posedge clock);
    #1;
    in_valid[1] = 1'b0;

    // Reset with both stages full; leaves ptr at 3 before the reset.
    wait_drain("pre_rst");
    out_ready   = 1'b0;
    in_a[2]     = 8'h40;
    in_b[2]     = 8'h40;
    exp_tbl[2]  = 8'h40;
    in_valid[2] = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    in_valid[2] = 1'b0;
    check("pre_rst_out_valid", out_valid, 1);
    check("pre_rst_busy", busy, 1);
    resetn = 1'b0;
    #1;
    flushed += exp_q.size();
    exp_q.delete();
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_data", out_data, 0);
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    repeat (4) begin
      @(negedge clock);
      check("post_rst_no_stale", out_valid, 0);
    end

    // Round robin from a freshly reset pointer: grants 0,1,2,3,0.
    @(posedge clock);
    #1;
    for (int r = 0; r < N; r++) begin
      in_a[r]    = 8'h40;
      in_b[r]    = rr_b[r];
      exp_tbl[r] = rr_b[r];
    end
    in_valid = '1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("rr_grant", in_ready, 32'(1) << (k % 4));
    end
    @(posedge clock);
    #1;
    in_valid = '0;

    wait_drain("final");
    check("push_pop_balance", 32'(popped), 32'(pushed - flushed));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: actual sim time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
